// File: rtl/main_memory_responder_pkg.sv
// Shared types and default constants for the main memory responder.
// Holds the FSM state encoding, parameter defaults and the reset image rule.
// The reset image of word i is i * INIT_MULT, truncated to the word width.
package main_memory_responder_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_DEPTH  = 16;
  localparam int DEF_LATENCY    = 3;
  localparam int INIT_MULT      = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Reset-time content of memory word idx (caller truncates to the word width).
  function automatic int unsigned init_word(input int unsigned idx);
    return idx * INIT_MULT;
  endfunction

endpackage

// File: rtl/main_memory_responder_latency_counter.sv
// Purpose: down-counter that times the wait phase of one memory access.
// Latency: zero flag reflects the registered count (updates one edge after load/enable).
// Backpressure: none; it saturates at zero until reloaded.
module mem_latency_counter
  import main_memory_responder_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over enable; stop at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/main_memory_responder.sv
// Purpose: single-outstanding memory model answering cache fills and writes.
// Latency: response valid LATENCY edges after the acceptance edge (LATENCY+1 edges inclusive).
// Backpressure: response held stable until resp_ready; no new request accepted until then.
module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  // Result captured at acceptance, presented once the wait phase ends.
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_err_q, hold_err_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  assign in_range = (req_addr < ADDR_WIDTH'(MEM_DEPTH));
  assign idx      = req_addr[IDX_W-1:0];

  mem_latency_counter #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(LATENCY - 1)),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // Next-state, memory update and output staging for the three-state access FSM.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    hold_data_d  = hold_data_q;
    hold_err_d   = hold_err_q;
    mem_d        = mem_q;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = WAIT;
          req_ready_d = 1'b0;
          cnt_load    = 1'b1;
          if (!in_range) begin
            // Out-of-range: no memory effect, zero data, error flagged.
            hold_data_d = '0;
            hold_err_d  = 1'b1;
          end else if (req_write) begin
            mem_d[idx]  = req_wdata;
            hold_data_d = req_wdata;
            hold_err_d  = 1'b0;
          end else begin
            hold_data_d = mem_q[idx];
            hold_err_d  = 1'b0;
          end
        end
      end
      WAIT: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = hold_data_q;
          resp_err_d   = hold_err_q;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_data_d  = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  // FSM and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      hold_data_q  <= hold_data_d;
      hold_err_q   <= hold_err_d;
    end
  end

  // Storage array; reset reloads the i*100 image over any earlier writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= DATA_WIDTH'(init_word(i));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder with default parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected words come from the i*100 reset image and the writes issued here.
module tb_main_memory_responder;

  localparam int LAT = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  int vectors;
  int miscompares;

  main_memory_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One complete access; hold = extra RESP cycles with resp_ready low.
  task automatic do_req(input string tag, input logic w, input logic [15:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_d,
                        input logic exp_e, input int hold);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, ":ready_before"}, req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    resp_ready = (hold == 0);
    @(posedge clk); #1;               // acceptance edge (edge 1)
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    chk({tag, ":busy"}, req_ready, 0);
    for (int i = 0; i < LAT - 1; i++) begin
      @(posedge clk); #1;             // edges 2..LAT: still waiting
      chk({tag, ":wait_valid"}, resp_valid, 0);
      chk({tag, ":wait_data"}, resp_data, 0);
    end
    @(posedge clk); #1;               // edge LAT+1: response up
    chk({tag, ":valid"}, resp_valid, 1);
    chk({tag, ":data"}, resp_data, exp_d);
    chk({tag, ":err"}, resp_err, exp_e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ":hold_valid"}, resp_valid, 1);
      chk({tag, ":hold_data"}, resp_data, exp_d);
      chk({tag, ":hold_err"}, resp_err, exp_e);
      chk({tag, ":hold_busy"}, req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ":idle_ready"}, req_ready, 1);
    chk({tag, ":idle_valid"}, resp_valid, 0);
    chk({tag, ":idle_data"}, resp_data, 0);
    chk({tag, ":idle_err"}, resp_err, 0);
    resp_ready = 1'b0;
  endtask

  initial begin
    logic        bw [3];
    logic [15:0] ba [3];
    logic [31:0] bd [3];
    logic [31:0] be [3];
    int hs, rs;
    logic take, prev_resp;

    vectors = 0;
    miscompares = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst:req_ready", req_ready, 1);
    chk("rst:resp_valid", resp_valid, 0);
    chk("rst:resp_data", resp_data, 0);
    chk("rst:resp_err", resp_err, 0);

    // Read of reset image, then write/read-back
    do_req("rd1", 1'b0, 16'h0001, 32'h0, 32'h0000_0064, 1'b0, 0);
    do_req("wr3", 1'b1, 16'h0003, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
    do_req("rd3", 1'b0, 16'h0003, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Response backpressure
    do_req("rd2_hold", 1'b0, 16'h0002, 32'h0, 32'h0000_00C8, 1'b0, 5);

    // Reset reloads the image over the earlier write; then range errors
    do_reset();
    do_req("rd_oor", 1'b0, 16'h0010, 32'h0, 32'h0, 1'b1, 0);
    do_req("wr_oor", 1'b1, 16'h8003, 32'hCAFE_F00D, 32'h0, 1'b1, 0);
    do_req("rd3_init", 1'b0, 16'h0003, 32'h0, 32'h0000_012C, 1'b0, 0);

    // Reset during WAIT aborts the read and restores word 4
    do_req("wr4", 1'b1, 16'h0004, 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0004;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort:in_wait", req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort:ready", req_ready, 1);
    chk("abort:valid", resp_valid, 0);
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk); #1;
      chk("abort:no_resp", resp_valid, 0);
    end
    do_req("rd4_init", 1'b0, 16'h0004, 32'h0, 32'h0000_0190, 1'b0, 0);

    // Back-to-back with req_valid held high across three requests
    bw[0] = 1'b0; ba[0] = 16'h0005; bd[0] = 32'h0;         be[0] = 32'h0000_01F4;
    bw[1] = 1'b1; ba[1] = 16'h0007; bd[1] = 32'hA5A5_A5A5; be[1] = 32'hA5A5_A5A5;
    bw[2] = 1'b0; ba[2] = 16'h0007; bd[2] = 32'h0;         be[2] = 32'hA5A5_A5A5;
    hs = 0; rs = 0; prev_resp = 1'b0;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_write = bw[0]; req_addr = ba[0]; req_wdata = bd[0];
    for (int cyc = 0; cyc < 60 && rs < 3; cyc++) begin
      if (prev_resp) chk("b2b:ready_after_resp", req_ready, 1);
      chk("b2b:no_accept_in_resp", req_ready & resp_valid, 0);
      prev_resp = resp_valid & resp_ready;
      if (resp_valid) begin
        chk("b2b:data", resp_data, be[rs]);
        chk("b2b:err", resp_err, 0);
        rs++;
      end
      take = req_valid & req_ready;
      @(posedge clk); #1;
      if (take) begin
        hs++;
        if (hs < 3) begin
          req_write = bw[hs]; req_addr = ba[hs]; req_wdata = bd[hs];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b:handshakes", hs, 3);
    chk("b2b:responses", rs, 3);
    resp_ready = 1'b0;
    req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, request address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 16, number of words (power of two, >= 2).
REQ-004 The block SHALL have parameter LATENCY, default 3, wait cycles per access (>= 1).
REQ-005 The block SHALL have port clk, input, 1, the only clock; all logic on rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port req_valid, input, 1, cache-side request present.
REQ-008 The block SHALL have port req_ready, output, 1, responder can accept a request.
REQ-009 The block SHALL have port req_write, input, 1, 1 = write, 0 = read/line fill.
REQ-010 The block SHALL have port req_addr, input, ADDR_WIDTH, word address.
REQ-011 The block SHALL have port req_wdata, input, DATA_WIDTH, write data.
REQ-012 The block SHALL have port resp_valid, output, 1, response present.
REQ-013 The block SHALL have port resp_ready, input, 1, cache accepts the response.
REQ-014 The block SHALL have port resp_data, output, DATA_WIDTH, read data, or written data for writes.
REQ-015 The block SHALL have port resp_err, output, 1, address out of range.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, WAIT and RESP; req_ready = (state == IDLE); resp_valid = (state == RESP).
REQ-017 A request SHALL be accepted on an edge where req_valid && req_ready; req_write, req_addr and req_wdata are captured on that edge; IDLE -> WAIT with the latency counter loaded with LATENCY-1.
REQ-018 In WAIT the counter SHALL decrement each cycle; when the counter is 0, WAIT -> RESP; resp_valid rises after exactly LATENCY+1 edges from the acceptance edge.
REQ-019 In RESP all response outputs SHALL hold stable until the edge where resp_ready = 1, then RESP -> IDLE; resp_ready is ignored outside RESP.
REQ-020 Exactly one request SHALL be outstanding at a time; req_valid is ignored outside IDLE, and back-to-back requests see req_ready high on the cycle after the handshake completes.
REQ-021 Range check: addresses with req_addr < MEM_DEPTH SHALL be in range and index word req_addr[log2(MEM_DEPTH)-1:0].
REQ-022 Out-of-range addresses (any upper bit set) SHALL give resp_err = 1 and resp_data = 0, with memory unchanged and the same latency.
REQ-023 A read SHALL sample memory on the acceptance edge and drive that value on resp_data.
REQ-024 A write SHALL update memory on the acceptance edge; its response carries resp_data = req_wdata, resp_err = 0.
REQ-025 A read following a write to the same address SHALL return the new data.
REQ-026 Outside RESP, resp_data and resp_err SHALL be 0.

Reset
REQ-027 On reset the block SHALL set state = IDLE, counter = 0, req_ready = 1, resp_valid = 0, resp_data = 0 and resp_err = 0.
REQ-028 On reset every memory word i SHALL be re-initialised to i*100 (width-truncated).
REQ-029 A reset asserted in WAIT or RESP SHALL abort the access, drop any pending response, and let the next cycle accept a new request.
REQ-030 A write accepted before the reset SHALL be overwritten by the initialisation.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/WAIT/RESP) and the default constants (ADDR_WIDTH, DATA_WIDTH, MEM_DEPTH, LATENCY, init multiplier 100).
REQ-032 The latency down-counter SHALL be one sub-module, mem_latency_counter, with inputs load, load value and enable, and output zero flag.
REQ-033 The storage array and the FSM SHALL stay in the top module.

Verification
REQ-034 Reset, then read 0x0001 with resp_ready = 1 -> resp_valid high 4 edges after acceptance, resp_data = 0x00000064, resp_err = 0.
REQ-035 Write 0x0003 with 0xDEADBEEF, then read 0x0003 -> write response carries data 0xDEADBEEF; read returns 0xDEADBEEF.
REQ-036 Read 0x0002 with resp_ready held low for 5 cycles -> resp_valid and resp_data = 0x000000C8 stable throughout, req_ready low; IDLE one edge after resp_ready rises.
REQ-037 Read 0x0010 and write 0x8003 -> resp_err = 1, resp_data = 0; a following read of 0x0003 returns 0x0000012C.
REQ-038 Write 0x0004 with 0x12345678, then assert reset during WAIT of a read -> no resp_valid; after reset a read of 0x0004 returns 0x00000190.
REQ-039 Keep req_valid high continuously across 3 requests -> exactly 3 handshakes, each response in order, no request accepted while resp_valid = 1.
